control_fsm: RTL
================

Name: control_fsm

Overview:
- Multi-cycle RV32I control unit that sits directly upstream of the data path.
- Decodes the latched instruction word and sequences fetch / execute / memory / writeback.
- Drives every data-path control strobe and select, plus the memory write strobe and CSR/trap sideband.
- One instruction retires every 2–4 cycles; no pipelining.

Parameters:
TRAP_ON_ILLEGAL, 1, when 1 an unknown opcode enters TRAP with cause 2; when 0 it executes as a NOP.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; state goes to FETCH
instruction  input  32  latched instruction from the data path
execute_result_write_enable, load_memory_data_write_enable, pc_write_enable, instruction_write_enable, register_file_write_enable  output  1 each  data-path strobes
write_immediate_to_register_file, write_load_memory_to_register_file, write_execute_result_to_pc, write_execute_result_to_pc_if_compare_met, write_pc_inc_to_register_file, use_execute_result_for_read_memory  output  1 each  data-path selects
execute_alu, execute_compare, execute_shift, execute_csr, use_immediate, use_immediate_for_compare, use_pc_for_alu, handle_trap, exit_trap  output  1 each  execute selects
immediate_type  output  3  I=0, S=1, B=2, U=3, J=4
alu_type  output  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4
shift_type  output  2  SLL=0, SRL=1, SRA=2
compare_type  output  3  funct3 branch codes; SLT/SLTI=3'b100, SLTU/SLTIU=3'b110
load_memory_decoder_type  output  3  funct3
store_memory_encoder_type  output  2  funct3[1:0]
memory_write_enable  output  1  store strobe, one cycle
csr_write_enable  output  1  CSR update strobe; csr_op = funct3[1:0]
csr_op  output  2  CSR operation
trap_cause  output  4  valid with handle_trap: 2 illegal, 3 ebreak, 11 ecall
retire  output  1  one-cycle pulse on the cycle pc_write_enable is asserted
state  output  3  debug

Behaviour:
- States:
  - FETCH=0
  - EXECUTE=1
  - WRITEBACK=2
  - JUMP=3
  - BRANCH=4
  - LOAD_READ=5
  - LOAD_WB=6
  - STORE=7
  - TRAP is a flag-qualified EXECUTE exit (see below).
- Registered state only; all outputs are combinational from state and instruction.
- Every output is 0 while reset is high. Reset mid-instruction abandons it; no strobe fires; first cycle after release is FETCH.
- Unlisted outputs are 0 in each state.
- FETCH: instruction_write_enable=1 -> EXECUTE.
- EXECUTE: execute_result_write_enable=1 for every opcode except LUI, FENCE and trap cases.
  - OP / OP-IMM: route by funct3 (funct7[5] selects SUB and SRA).
    - ADD/SUB/AND/OR/XOR -> execute_alu.
    - SLT(U) -> execute_compare; use_immediate_for_compare=1 for OP-IMM.
    - Shifts -> execute_shift.
    - use_immediate=1 and immediate_type=I for OP-IMM.
    - Next state WRITEBACK.
  - LUI: immediate_type=U, write_immediate_to_register_file, register_file_write_enable, pc_write_enable -> FETCH.
  - AUIPC: execute_alu, ADD, use_pc_for_alu, use_immediate, U -> WRITEBACK.
  - JAL: same as AUIPC with J -> JUMP.
  - JALR: ADD rs1+imm, I -> JUMP. Bit 0 is not cleared.
  - BRANCH: execute_alu, ADD, use_pc_for_alu, use_immediate, B; compare_type=funct3; use_immediate_for_compare=0 -> BRANCH.
  - LOAD: ADD rs1+imm I -> LOAD_READ.
  - STORE: ADD rs1+imm S -> STORE.
  - SYSTEM, funct3≠0: execute_csr, csr_write_enable, csr_op; use_immediate=funct3[2] -> WRITEBACK.
  - ECALL/EBREAK: handle_trap, pc_write_enable, trap_cause 11/3 -> FETCH.
  - MRET (0x30200073): exit_trap -> JUMP, with write_pc_inc_to_register_file suppressed.
  - FENCE: pc_write_enable -> FETCH.
  - Illegal opcode: handle_trap, pc_write_enable, cause 2 -> FETCH.
- WRITEBACK: register_file_write_enable, pc_write_enable -> FETCH.
- JUMP: write_execute_result_to_pc, pc_write_enable; register_file_write_enable and write_pc_inc_to_register_file unless MRET -> FETCH.
- BRANCH: write_execute_result_to_pc_if_compare_met, pc_write_enable -> FETCH.
- LOAD_READ: use_execute_result_for_read_memory, load_memory_data_write_enable, load_memory_decoder_type=funct3 -> LOAD_WB.
- LOAD_WB: write_load_memory_to_register_file, register_file_write_enable, pc_write_enable -> FETCH.
- STORE: memory_write_enable, store_memory_encoder_type, pc_write_enable -> FETCH.
- rd=x0: strobes still asserted; the register file discards the write.
- Latency (FETCH to next FETCH):
  - 2 cycles: LUI, FENCE, trap.
  - 3 cycles: ALU, CSR, JAL/JALR, branch, store.
  - 4 cycles: load.

Test Plan:
- Reset high in LOAD_READ with instruction 0x0000A083 (lw) -> all outputs 0 immediately; after release state=0, instruction_write_enable=1.
- addi x1,x0,5 (0x00500093) -> cycle 1 FETCH; cycle 2 execute_alu=1, use_immediate=1, immediate_type=0; cycle 3 register_file_write_enable=1, pc_write_enable=1, retire=1.
- beq x0,x0,+8 (0x00000463) -> cycle 2 compare_type=0, use_pc_for_alu=1, immediate_type=2; cycle 3 write_execute_result_to_pc_if_compare_met=1, pc_write_enable=1.
- lw x1,0(x1) -> states 0,1,5,6; LOAD_READ has load_memory_decoder_type=2 and use_execute_result_for_read_memory=1.
- sb (0x00108023) -> state 7 with memory_write_enable=1, store_memory_encoder_type=0, exactly one cycle.
- ecall 0x00000073 -> handle_trap=1, trap_cause=11. Opcode 0x0000007F -> trap_cause=2 (TRAP_ON_ILLEGAL=1), or NOP with retire after 2 cycles (TRAP_ON_ILLEGAL=0).

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I sequencer; drives every data-path strobe/select from state + latched instruction.
// Latency 2-4 cycles FETCH to FETCH; no backpressure, the FSM advances every cycle.
module control_fsm #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        execute_result_write_enable,
    output logic        load_memory_data_write_enable,
    output logic        pc_write_enable,
    output logic        instruction_write_enable,
    output logic        register_file_write_enable,
    output logic        write_immediate_to_register_file,
    output logic        write_load_memory_to_register_file,
    output logic        write_execute_result_to_pc,
    output logic        write_execute_result_to_pc_if_compare_met,
    output logic        write_pc_inc_to_register_file,
    output logic        use_execute_result_for_read_memory,
    output logic        execute_alu,
    output logic        execute_compare,
    output logic        execute_shift,
    output logic        execute_csr,
    output logic        use_immediate,
    output logic        use_immediate_for_compare,
    output logic        use_pc_for_alu,
    output logic        handle_trap,
    output logic        exit_trap,
    output logic [2:0]  immediate_type,
    output logic [2:0]  alu_type,
    output logic [1:0]  shift_type,
    output logic [2:0]  compare_type,
    output logic [2:0]  load_memory_decoder_type,
    output logic [1:0]  store_memory_encoder_type,
    output logic        memory_write_enable,
    output logic        csr_write_enable,
    output logic [1:0]  csr_op,
    output logic [3:0]  trap_cause,
    output logic        retire,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, EXECUTE = 3'd1, WRITEBACK = 3'd2, JUMP = 3'd3,
        BRANCH = 3'd4, LOAD_READ = 3'd5, LOAD_WB = 3'd6, STORE = 3'd7
    } state_t;

    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                           OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                           OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                           OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_XOR = 3'd4;
    localparam logic [1:0] SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, is_ecall, is_ebreak, is_mret, is_legal, exec_short;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7b5  = instruction[30];
    assign is_ecall  = (instruction == 32'h0000_0073);
    assign is_ebreak = (instruction == 32'h0010_0073);
    assign is_mret   = (instruction == 32'h3020_0073);

    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_FENCE: is_legal = 1'b1;
            OPC_SYSTEM: is_legal = (funct3[1:0] != 2'b00) || is_ecall || is_ebreak || is_mret;
            default:    is_legal = 1'b0;
        endcase
    end

    // Instructions that finish in EXECUTE; illegal ones return to FETCH whether trapped or not.
    assign exec_short = (opcode == OPC_LUI) || (opcode == OPC_FENCE) || is_ecall || is_ebreak || !is_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = EXECUTE;
            EXECUTE: begin
                if (!exec_short) begin
                    case (opcode)
                        OPC_JAL, OPC_JALR: state_d = JUMP;
                        OPC_BRANCH:        state_d = BRANCH;
                        OPC_LOAD:          state_d = LOAD_READ;
                        OPC_STORE:         state_d = STORE;
                        OPC_SYSTEM:        state_d = is_mret ? JUMP : WRITEBACK;
                        default:           state_d = WRITEBACK;
                    endcase
                end
            end
            LOAD_READ: state_d = LOAD_WB;
            default:   state_d = FETCH;
        endcase
    end

    always_comb begin
        execute_result_write_enable = 1'b0;  load_memory_data_write_enable = 1'b0;
        pc_write_enable = 1'b0;              instruction_write_enable = 1'b0;
        register_file_write_enable = 1'b0;   write_immediate_to_register_file = 1'b0;
        write_load_memory_to_register_file = 1'b0; write_execute_result_to_pc = 1'b0;
        write_execute_result_to_pc_if_compare_met = 1'b0; write_pc_inc_to_register_file = 1'b0;
        use_execute_result_for_read_memory = 1'b0; execute_alu = 1'b0;
        execute_compare = 1'b0;  execute_shift = 1'b0;  execute_csr = 1'b0;
        use_immediate = 1'b0;    use_immediate_for_compare = 1'b0;  use_pc_for_alu = 1'b0;
        handle_trap = 1'b0;      exit_trap = 1'b0;
        immediate_type = IMM_I;  alu_type = ALU_ADD;  shift_type = SH_SLL;  compare_type = 3'd0;
        load_memory_decoder_type = 3'd0;  store_memory_encoder_type = 2'd0;
        memory_write_enable = 1'b0;  csr_write_enable = 1'b0;  csr_op = 2'd0;  trap_cause = 4'd0;
        if (!reset) begin
            case (state_q)
                FETCH: instruction_write_enable = 1'b1;
                EXECUTE: begin
                    if (!is_legal) begin
                        pc_write_enable = 1'b1;
                        if (TRAP_ON_ILLEGAL) begin
                            handle_trap = 1'b1;
                            trap_cause  = 4'd2;
                        end
                    end else begin
                        case (opcode)
                            OPC_OP, OPC_OPIMM: begin
                                execute_result_write_enable = 1'b1;
                                use_immediate = (opcode == OPC_OPIMM);
                                case (funct3)
                                    3'b000: begin
                                        execute_alu = 1'b1;
                                        alu_type = (opcode == OPC_OP && funct7b5) ? ALU_SUB : ALU_ADD;
                                    end
                                    3'b001: execute_shift = 1'b1;
                                    3'b010, 3'b011: begin
                                        execute_compare = 1'b1;
                                        compare_type = funct3[0] ? 3'b110 : 3'b100;
                                        use_immediate_for_compare = (opcode == OPC_OPIMM);
                                    end
                                    3'b100: begin execute_alu = 1'b1; alu_type = ALU_XOR; end
                                    3'b101: begin
                                        execute_shift = 1'b1;
                                        shift_type = funct7b5 ? SH_SRA : SH_SRL;
                                    end
                                    3'b110: begin execute_alu = 1'b1; alu_type = ALU_OR; end
                                    default: begin execute_alu = 1'b1; alu_type = ALU_AND; end
                                endcase
                            end
                            OPC_LUI: begin
                                immediate_type = IMM_U;
                                write_immediate_to_register_file = 1'b1;
                                register_file_write_enable = 1'b1;
                                pc_write_enable = 1'b1;
                            end
                            OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
                                execute_result_write_enable = 1'b1;
                                execute_alu = 1'b1;
                                use_pc_for_alu = 1'b1;
                                use_immediate = 1'b1;
                                immediate_type = (opcode == OPC_AUIPC) ? IMM_U :
                                                 (opcode == OPC_JAL)   ? IMM_J : IMM_B;
                                if (opcode == OPC_BRANCH) compare_type = funct3;
                            end
                            OPC_JALR, OPC_LOAD, OPC_STORE: begin
                                execute_result_write_enable = 1'b1;
                                execute_alu = 1'b1;
                                use_immediate = 1'b1;
                                immediate_type = (opcode == OPC_STORE) ? IMM_S : IMM_I;
                            end
                            OPC_FENCE: pc_write_enable = 1'b1;
                            OPC_SYSTEM: begin
                                if (is_ecall || is_ebreak) begin
                                    handle_trap = 1'b1;
                                    pc_write_enable = 1'b1;
                                    trap_cause = is_ecall ? 4'd11 : 4'd3;
                                end else if (is_mret) begin
                                    execute_result_write_enable = 1'b1;
                                    exit_trap = 1'b1;
                                end else begin
                                    execute_result_write_enable = 1'b1;
                                    execute_csr = 1'b1;
                                    csr_write_enable = 1'b1;
                                    csr_op = funct3[1:0];
                                    use_immediate = funct3[2];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WRITEBACK: begin
                    register_file_write_enable = 1'b1;
                    pc_write_enable = 1'b1;
                end
                JUMP: begin
                    write_execute_result_to_pc = 1'b1;
                    pc_write_enable = 1'b1;
                    register_file_write_enable = !is_mret;
                    write_pc_inc_to_register_file = !is_mret;
                end
                BRANCH: begin
                    write_execute_result_to_pc_if_compare_met = 1'b1;
                    pc_write_enable = 1'b1;
                end
                LOAD_READ: begin
                    use_execute_result_for_read_memory = 1'b1;
                    load_memory_data_write_enable = 1'b1;
                    load_memory_decoder_type = funct3;
                end
                LOAD_WB: begin
                    write_load_memory_to_register_file = 1'b1;
                    register_file_write_enable = 1'b1;
                    pc_write_enable = 1'b1;
                end
                default: begin
                    memory_write_enable = 1'b1;
                    store_memory_encoder_type = funct3[1:0];
                    pc_write_enable = 1'b1;
                end
            endcase
        end
    end

    assign retire = pc_write_enable;
    assign state  = state_q;
endmodule
